// File: rtl/fetch_ctrl_if.sv
// Stall, redirect and fetch-status signals exchanged between fetch_ctrl and
// the surrounding pipeline stages.
interface fetch_ctrl_if #(
    parameter int PC_WIDTH = 16
);
    logic                I_BranchStallSignal;
    logic                I_DepStallSignal;
    logic                I_GPUStallSignal;
    logic                I_BranchAddrSelect;
    logic [PC_WIDTH-1:0] I_BranchPC;
    logic                O_LOCK;
    logic [PC_WIDTH-1:0] O_PC;
    logic                O_Hold;
    logic                O_InjectNOP;
    logic                O_FE_Valid;
    logic [2:0]          O_State;

    // Controller side: consumes stall/redirect requests, produces fetch status.
    modport master (
        input  I_BranchStallSignal, I_DepStallSignal, I_GPUStallSignal,
        input  I_BranchAddrSelect, I_BranchPC,
        output O_LOCK, O_PC, O_Hold, O_InjectNOP, O_FE_Valid, O_State
    );

    modport slave (
        output I_BranchStallSignal, I_DepStallSignal, I_GPUStallSignal,
        output I_BranchAddrSelect, I_BranchPC,
        input  O_LOCK, O_PC, O_Hold, O_InjectNOP, O_FE_Valid, O_State
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC and picks advance / hold / redirect /
// NOP-bubble each falling edge from the decode, memory and GPU stall sources.
module fetch_ctrl #(
    parameter int PC_WIDTH = 16,
    parameter int BUBBLES  = 2
) (
    input  logic         I_CLOCK,
    input  logic         I_LOCK,
    fetch_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        HOLD    = 3'd2,
        BR_WAIT = 3'd3,
        BUBBLE  = 3'd4
    } state_t;

    localparam logic [2:0] BUB_LIMIT = 3'(BUBBLES);

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                hold_q, hold_d;
    logic                nop_q, nop_d;
    logic                valid_q, valid_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                lock_q;

    function automatic logic [2:0] sat_inc(input logic [2:0] c);
        if (c >= BUB_LIMIT) return BUB_LIMIT;
        return c + 3'd1;
    endfunction

    // Pipeline latches update on the falling edge, so this block does too.
    always_ff @(negedge I_CLOCK) begin
        lock_q <= I_LOCK;
        if (!I_LOCK) begin
            state_q <= IDLE;
            pc_q    <= '0;
            hold_q  <= 1'b0;
            nop_q   <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            nop_q   <= nop_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hold_d  = hold_q;
        nop_d   = nop_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                // First fetch comes from address 0, so the PC is not bumped here.
                state_d = RUN;
                hold_d  = 1'b0;
                nop_d   = 1'b0;
                valid_d = 1'b1;
                cnt_d   = 3'd0;
            end
            RUN, HOLD, BR_WAIT, BUBBLE: begin
                if (bus.I_BranchAddrSelect) begin
                    state_d = RUN;
                    pc_d    = bus.I_BranchPC;
                    hold_d  = 1'b0;
                    nop_d   = 1'b0;
                    valid_d = 1'b1;
                    cnt_d   = 3'd0;
                end else if (bus.I_GPUStallSignal || bus.I_DepStallSignal) begin
                    // A bubble in progress just freezes; everything else parks in HOLD.
                    if (state_q != BUBBLE) begin
                        state_d = HOLD;
                        hold_d  = 1'b1;
                        nop_d   = 1'b0;
                        valid_d = 1'b1;
                    end
                end else if (bus.I_BranchStallSignal) begin
                    state_d = BR_WAIT;
                    hold_d  = 1'b0;
                    nop_d   = 1'b1;
                    valid_d = 1'b0;
                    cnt_d   = 3'd0;
                end else if (state_q == BR_WAIT && BUB_LIMIT != 3'd0) begin
                    state_d = BUBBLE;
                    hold_d  = 1'b0;
                    nop_d   = 1'b1;
                    valid_d = 1'b0;
                    cnt_d   = 3'd0;
                end else if (state_q == BUBBLE && sat_inc(cnt_q) != BUB_LIMIT) begin
                    cnt_d   = sat_inc(cnt_q);
                    hold_d  = 1'b0;
                    nop_d   = 1'b1;
                    valid_d = 1'b0;
                end else begin
                    if (state_q == BUBBLE) cnt_d = sat_inc(cnt_q);
                    state_d = RUN;
                    pc_d    = pc_q + PC_WIDTH'(4);
                    hold_d  = 1'b0;
                    nop_d   = 1'b0;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = 1'b0;
                nop_d   = 1'b0;
                valid_d = 1'b0;
                cnt_d   = 3'd0;
            end
        endcase
    end

    assign bus.O_LOCK      = lock_q;
    assign bus.O_PC        = pc_q;
    assign bus.O_Hold      = hold_q;
    assign bus.O_InjectNOP = nop_q;
    assign bus.O_FE_Valid  = valid_q;
    assign bus.O_State     = state_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed test-plan sequences followed by
// random stall/redirect traffic, checked against a countdown-style model.
module tb_fetch_ctrl;
    localparam int PW  = 16;
    localparam int BUB = 2;

    logic clk = 1'b0;
    logic lock;

    always #5 clk = ~clk;

    fetch_ctrl_if #(.PC_WIDTH(PW)) bus ();

    fetch_ctrl #(.PC_WIDTH(PW), .BUBBLES(BUB)) dut (
        .I_CLOCK(clk),
        .I_LOCK (lock),
        .bus    (bus)
    );

    typedef struct {
        logic          lk;
        logic [PW-1:0] pc;
        logic          hold;
        logic          nop;
        logic          valid;
        logic [2:0]    st;
        int            id;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_issued = 0;

    // Reference model: "started" flag, flat integer PC and a bubble countdown.
    bit   started      = 0;
    int   pc_m         = 0;
    bit   holding      = 0;
    bit   waiting      = 0;
    int   bubbles_left = 0;
    exp_t last;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want, input int id);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s step=%0d got=%0h want=%0h", nm, id, act, want);
        end
    endtask

    task automatic step(input bit lk, input bit br, input bit dep, input bit gpu,
                        input bit sel, input logic [PW-1:0] bpc);
        exp_t e;
        bit   adv;
        @(posedge clk);
        lock                    = lk;
        bus.I_BranchStallSignal = br;
        bus.I_DepStallSignal    = dep;
        bus.I_GPUStallSignal    = gpu;
        bus.I_BranchAddrSelect  = sel;
        bus.I_BranchPC          = bpc;

        e    = last;
        e.id = n_issued;
        if (!lk) begin
            started = 0; pc_m = 0; holding = 0; waiting = 0; bubbles_left = 0;
            e.hold = 0; e.nop = 0; e.valid = 0;
        end else if (!started) begin
            started = 1;
            e.hold = 0; e.nop = 0; e.valid = 1;
        end else if (sel) begin
            pc_m = int'(bpc); holding = 0; waiting = 0; bubbles_left = 0;
            e.hold = 0; e.nop = 0; e.valid = 1;
        end else if (gpu || dep) begin
            if (bubbles_left == 0) begin
                holding = 1; waiting = 0;
                e.hold = 1; e.nop = 0; e.valid = 1;
            end
        end else if (br) begin
            waiting = 1; holding = 0; bubbles_left = 0;
            e.hold = 0; e.nop = 1; e.valid = 0;
        end else begin
            adv = 1;
            if (waiting) begin
                waiting = 0;
                if (BUB > 0) begin
                    bubbles_left = BUB;
                    adv = 0;
                end
            end else if (bubbles_left > 0) begin
                bubbles_left--;
                if (bubbles_left > 0) adv = 0;
            end
            holding = 0;
            if (adv) begin
                pc_m = (pc_m + 4) % 65536;
                e.hold = 0; e.nop = 0; e.valid = 1;
            end else begin
                e.hold = 0; e.nop = 1; e.valid = 0;
            end
        end
        e.lk = lk;
        e.pc = PW'(pc_m);
        if (!started)              e.st = 3'd0;
        else if (bubbles_left > 0) e.st = 3'd4;
        else if (waiting)          e.st = 3'd3;
        else if (holding)          e.st = 3'd2;
        else                       e.st = 3'd1;
        last = e;
        q.push_back(e);
        n_issued++;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, '0);
    endtask

    // Monitor: every falling edge produces one registered output word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("O_LOCK",      32'(bus.O_LOCK),      32'(e.lk),    e.id);
                chk("O_PC",        32'(bus.O_PC),        32'(e.pc),    e.id);
                chk("O_Hold",      32'(bus.O_Hold),      32'(e.hold),  e.id);
                chk("O_InjectNOP", 32'(bus.O_InjectNOP), 32'(e.nop),   e.id);
                chk("O_FE_Valid",  32'(bus.O_FE_Valid),  32'(e.valid), e.id);
                chk("O_State",     32'(bus.O_State),     32'(e.st),    e.id);
            end
        end
    end

    initial begin
        lock                    = 1'b0;
        bus.I_BranchStallSignal = 1'b0;
        bus.I_DepStallSignal    = 1'b0;
        bus.I_GPUStallSignal    = 1'b0;
        bus.I_BranchAddrSelect  = 1'b0;
        bus.I_BranchPC          = '0;

        // Reset, then plain sequential fetch up to 0x10.
        step(0, 0, 0, 0, 0, '0);
        step(0, 0, 0, 0, 0, '0);
        run_n(5);
        // Branch stall at 0x10 for three cycles, then redirect to 0x40.
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, '0);
        step(1, 1, 0, 0, 1, 16'h0040);
        run_n(2);
        // Branch stall released with no redirect: two bubbles then advance.
        step(1, 1, 0, 0, 0, '0);
        step(1, 1, 0, 0, 0, '0);
        run_n(4);
        // Dep + branch stall, then dep drops: HOLD then BR_WAIT.
        step(1, 1, 1, 0, 0, '0);
        step(1, 1, 1, 0, 0, '0);
        step(1, 1, 0, 0, 0, '0);
        step(1, 1, 0, 0, 0, '0);
        run_n(4);
        // GPU stall in the middle of a bubble freezes the countdown.
        step(1, 1, 0, 0, 0, '0);
        run_n(2);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, '0);
        run_n(3);
        // PC wrap at the top of the address space.
        step(1, 0, 0, 0, 1, 16'hFFF8);
        run_n(3);
        // Reset while waiting on a branch.
        step(1, 1, 0, 0, 0, '0);
        step(1, 1, 0, 0, 0, '0);
        step(0, 1, 0, 0, 0, '0);
        run_n(3);
        // Unaligned redirect target, and redirect racing a GPU stall.
        step(1, 0, 0, 0, 1, 16'h1233);
        run_n(2);
        step(1, 1, 1, 1, 1, 16'h0200);
        step(1, 0, 0, 1, 0, '0);
        run_n(2);

        for (int i = 0; i < 900; i++) begin
            bit            lk, br, dep, gpu, sel;
            logic [PW-1:0] bpc;
            lk  = ($urandom_range(0, 79) != 0);
            br  = ($urandom_range(0, 3) == 0);
            dep = ($urandom_range(0, 9) == 0);
            gpu = ($urandom_range(0, 9) == 0);
            sel = ($urandom_range(0, 11) == 0);
            bpc = ($urandom_range(0, 3) == 0) ? 16'hFFF4 : PW'($urandom_range(0, 65535));
            step(lk, br, dep, gpu, sel, bpc);
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
